// File: rtl/controlador_rega.sv
// Irrigation sequencer: selects sprinkler (AS), drip (GT) or idle (US) from soil and tank sensors,
// enforces a dead-time interlock between valves and latches a fault on low tank or run timeout.
module controlador_rega #(
  parameter int unsigned DEAD_TIME = 4,
  parameter int unsigned MAX_RUN   = 1000,
  localparam int unsigned CW       = $clog2(MAX_RUN + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] umid,
  input  logic       tanque_baixo,
  input  logic       ack_alarme,
  output logic       AS,
  output logic       GT,
  output logic       US,
  output logic       alarm_wire,
  output logic [2:0] estado
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StDead  = 3'd1;
  localparam logic [2:0] StRunAs = 3'd2;
  localparam logic [2:0] StRunGt = 3'd3;
  localparam logic [2:0] StFault = 3'd4;

  localparam logic [CW-1:0] DeadLast = CW'(DEAD_TIME - 1);
  localparam logic [CW-1:0] RunLast  = CW'(MAX_RUN - 1);
  localparam logic [CW-1:0] CntMax   = {CW{1'b1}};

  logic [2:0]    state_q, state_d;
  logic          tgt_gt_q, tgt_gt_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          dry, want_gt;
  logic          as_q, gt_q, us_q, alarm_q;
  logic          as_d, gt_d, us_d, alarm_d;

  assign dry     = en && (umid != 2'b00);
  assign want_gt = (umid == 2'b01);
  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    tgt_gt_d = tgt_gt_q;
    cnt_d    = cnt_q;
    case (state_q)
      StIdle: begin
        if (dry) begin
          if (tanque_baixo) begin
            state_d = StFault;
          end else begin
            state_d  = StDead;
            tgt_gt_d = want_gt;
          end
        end
      end
      StDead: begin
        tgt_gt_d = want_gt;
        if (tanque_baixo) begin
          state_d = StFault;
        end else if (!dry) begin
          state_d = StIdle;
        end else if (cnt_q == DeadLast) begin
          // Target taken from the current umid so a late mode change is honoured.
          state_d = want_gt ? StRunGt : StRunAs;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StRunAs, StRunGt: begin
        if (tanque_baixo) begin
          state_d = StFault;
        end else if (cnt_q == RunLast) begin
          state_d = StFault;
        end else if (!dry) begin
          state_d = StIdle;
        end else if (want_gt != (state_q == StRunGt)) begin
          state_d  = StDead;
          tgt_gt_d = want_gt;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StFault: begin
        if (ack_alarme && !tanque_baixo) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  always_comb begin
    as_d    = 1'b0;
    gt_d    = 1'b0;
    us_d    = 1'b0;
    alarm_d = 1'b0;
    case (state_d)
      StIdle:  us_d    = 1'b1;
      StDead:  ;
      StRunAs: as_d    = 1'b1;
      StRunGt: gt_d    = 1'b1;
      StFault: alarm_d = 1'b1;
      default: us_d    = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      tgt_gt_q <= 1'b0;
      cnt_q    <= '0;
      as_q     <= 1'b0;
      gt_q     <= 1'b0;
      us_q     <= 1'b1;
      alarm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tgt_gt_q <= tgt_gt_d;
      cnt_q    <= cnt_d;
      as_q     <= as_d;
      gt_q     <= gt_d;
      us_q     <= us_d;
      alarm_q  <= alarm_d;
    end
  end

  assign AS         = as_q;
  assign GT         = gt_q;
  assign US         = us_q;
  assign alarm_wire = alarm_q;
  assign estado     = state_q;

endmodule

// File: tb/tb_controlador_rega.sv
// Bench for controlador_rega: directed test-plan sequence with literal pins, then random stimulus,
// all checked every cycle against a mode/dwell-time model of the sequencer.
module tb_controlador_rega;

  localparam int unsigned DT = 4;
  localparam int unsigned MR = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] umid = 2'b00;
  logic       tanque_baixo = 1'b0;
  logic       ack_alarme = 1'b0;
  logic       AS, GT, US, alarm_wire;
  logic [2:0] estado;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  controlador_rega #(
    .DEAD_TIME(DT),
    .MAX_RUN  (MR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .umid        (umid),
    .tanque_baixo(tanque_baixo),
    .ack_alarme  (ack_alarme),
    .AS          (AS),
    .GT          (GT),
    .US          (US),
    .alarm_wire  (alarm_wire),
    .estado      (estado)
  );

  always #5 clk = ~clk;

  // Model: mode 0 idle, 1 dead, 2 sprinkling, 3 dripping, 4 fault; dwell = cycles spent in mode.
  int m_mode = 0;
  int m_dwell = 0;

  function automatic int next_mode(int mode, int dwell, logic e, logic [1:0] u, logic tank,
                                   logic ack);
    bit dry = e && (u != 2'b00);
    int wanted = (u == 2'b01) ? 3 : 2;
    case (mode)
      0: return dry ? (tank ? 4 : 1) : 0;
      1: begin
        if (tank) return 4;
        if (!dry) return 0;
        return (dwell + 1 >= DT) ? wanted : 1;
      end
      2, 3: begin
        if (tank) return 4;
        if (dwell + 1 >= MR) return 4;
        if (!dry) return 0;
        return (wanted == mode) ? mode : 1;
      end
      default: return (ack && !tank) ? 0 : 4;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode  <= 0;
      m_dwell <= 0;
    end else begin
      m_mode  <= next_mode(m_mode, m_dwell, en, umid, tanque_baixo, ack_alarme);
      m_dwell <= (next_mode(m_mode, m_dwell, en, umid, tanque_baixo, ack_alarme) != m_mode)
                 ? 0 : m_dwell + 1;
    end
  end

  task automatic compare_loop();
    logic [6:0] got, want;
    forever begin
      @(negedge clk);
      cyc++;
      got  = {estado, AS, GT, US, alarm_wire};
      want = {3'(m_mode), m_mode == 2, m_mode == 3, m_mode == 0, m_mode == 4};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL cycle_outputs cyc=%0d {estado,AS,GT,US,alarm} got %b required %b",
                 cyc, got, want);
      end
      n_cmp++;
      if ((AS & GT) !== 1'b0) begin
        n_bad++;
        $display("FAIL valve_interlock cyc=%0d AS=%b GT=%b required not both 1", cyc, AS, GT);
      end
    end
  endtask

  // Literal expectation that pins both the DUT and the model.
  task automatic pin(string name, logic [2:0] e_est, logic [3:0] e_out);
    n_cmp++;
    if ({estado, AS, GT, US, alarm_wire} !== {e_est, e_out}) begin
      n_bad++;
      $display("FAIL %s estado=%0d {AS,GT,US,alarm}=%b required estado=%0d %b", name, estado,
               {AS, GT, US, alarm_wire}, e_est, e_out);
    end
    n_cmp++;
    if (m_mode != int'(e_est)) begin
      n_bad++;
      $display("FAIL %s_model mode=%0d required %0d", name, m_mode, e_est);
    end
  endtask

  task automatic edges(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    fork
      compare_loop();
    join_none

    // 1: start-up through dead time into sprinkler
    en = 1'b1; umid = 2'b10;
    #12 rst_n = 1'b1;
    edges(0); pin("reset_idle", 3'd0, 4'b0010);
    edges(1); pin("dead_first", 3'd1, 4'b0000);
    edges(3); pin("dead_last", 3'd1, 4'b0000);
    edges(1); pin("run_as", 3'd2, 4'b1000);
    // 2: mode change passes through DEAD
    umid = 2'b01;
    edges(1); pin("as_to_dead", 3'd1, 4'b0000);
    edges(3); pin("dead_hold", 3'd1, 4'b0000);
    edges(1); pin("run_gt", 3'd3, 4'b0100);
    // 3: timeout after exactly MR open cycles
    edges(MR - 1); pin("gt_last", 3'd3, 4'b0100);
    edges(1); pin("timeout", 3'd4, 4'b0001);
    ack_alarme = 1'b1;
    edges(1); pin("ack_idle", 3'd0, 4'b0010);
    ack_alarme = 1'b0; umid = 2'b11;
    // 4: low tank during run, ack ignored while still low
    edges(5); pin("run_as2", 3'd2, 4'b1000);
    tanque_baixo = 1'b1;
    edges(1); pin("tank_fault", 3'd4, 4'b0001);
    ack_alarme = 1'b1;
    edges(1); pin("ack_ignored", 3'd4, 4'b0001);
    tanque_baixo = 1'b0;
    edges(1); pin("ack_ok", 3'd0, 4'b0010);
    ack_alarme = 1'b0;
    // 5: disable beats mode change; wet soil in DEAD
    edges(5); pin("run_as3", 3'd2, 4'b1000);
    en = 1'b0; umid = 2'b01;
    edges(1); pin("disable_prio", 3'd0, 4'b0010);
    en = 1'b1; umid = 2'b10;
    edges(1); pin("dead_again", 3'd1, 4'b0000);
    umid = 2'b00;
    edges(1); pin("wet_in_dead", 3'd0, 4'b0010);
    // 6: asynchronous reset mid-run
    umid = 2'b01;
    edges(5); pin("run_gt2", 3'd3, 4'b0100);
    #2 rst_n = 1'b0;
    #1 pin("async_reset", 3'd0, 4'b0010);
    #3 rst_n = 1'b1;
    edges(1); pin("restart_dead", 3'd1, 4'b0000);
    edges(4); pin("restart_run", 3'd3, 4'b0100);

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      edges(1);
      en           = ($urandom_range(0, 99) < 92);
      if ($urandom_range(0, 99) < 6) umid = 2'($urandom_range(0, 3));
      tanque_baixo = ($urandom_range(0, 99) < 3);
      ack_alarme   = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 999) < 3) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    edges(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
